// File: rtl/scaler_cfg_ctrl.sv
// scaler_cfg_ctrl
//   Runtime configuration controller for the scaler. It debounces the
//   preset buttons, holds a host-writable preset table, and commits the
//   selected crop window and in/out resolution only at a frame boundary.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   button               raw active-high push buttons, button i selects preset i
//   frame_sync           frame-start strobe, level or pulse; rising edge is used
//   cfg_we/addr/field    host table write: entry, field (0..6, 7 ignored)
//   cfg_wdata            write data; input-side fields take the low bits
//   xBgn..inYRes         active crop window and input resolution
//   outXRes, outYRes     active output resolution
//   active_idx           index of the committed preset
//   cfg_pending          a selection is waiting for frame_sync
//   cfg_applied/cfg_err  one-cycle pulse for an accepted or rejected commit
module scaler_cfg_ctrl #(
  parameter int INPUT_RES_WIDTH  = 11,
  parameter int OUTPUT_RES_WIDTH = 11,
  parameter int NUM_BTN          = 4,
  parameter int NUM_PRESETS      = 4,
  parameter int IDX_W            = 2,
  parameter int DB_CYCLES        = 1000000,
  parameter int DB_W             = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_BTN-1:0]          button,
  input  logic                        frame_sync,
  input  logic                        cfg_we,
  input  logic [IDX_W-1:0]            cfg_addr,
  input  logic [2:0]                  cfg_field,
  input  logic [OUTPUT_RES_WIDTH:0]   cfg_wdata,
  output logic [INPUT_RES_WIDTH-1:0]  xBgn,
  output logic [INPUT_RES_WIDTH-1:0]  xEnd,
  output logic [INPUT_RES_WIDTH-1:0]  yBgn,
  output logic [INPUT_RES_WIDTH-1:0]  inXRes,
  output logic [INPUT_RES_WIDTH-1:0]  inYRes,
  output logic [OUTPUT_RES_WIDTH:0]   outXRes,
  output logic [OUTPUT_RES_WIDTH:0]   outYRes,
  output logic [IDX_W-1:0]            active_idx,
  output logic                        cfg_pending,
  output logic                        cfg_applied,
  output logic                        cfg_err
);

  localparam int IW = INPUT_RES_WIDTH;
  localparam int OW = OUTPUT_RES_WIDTH + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef struct packed {
    logic [IW-1:0] x_bgn;
    logic [IW-1:0] x_end;
    logic [IW-1:0] y_bgn;
    logic [IW-1:0] in_x;
    logic [IW-1:0] in_y;
    logic [OW-1:0] out_x;
    logic [OW-1:0] out_y;
  } preset_t;

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  // Power-on contents of table entry i; entry 0 doubles as the reset
  // value of the active registers.
  function automatic preset_t reset_preset(input int i);
    preset_t p;
    p.x_bgn = '0;
    p.x_end = IW'(1023);
    p.y_bgn = '0;
    p.in_x  = IW'(1024);
    p.in_y  = IW'(768);
    p.out_x = OW'(1024);
    p.out_y = OW'(768);
    if (i == 1) p.x_end = IW'(767);
    if (i == 2) p.x_end = IW'(511);
    if (i == 3) begin
      p.out_x = OW'(512);
      p.out_y = OW'(384);
    end
    return p;
  endfunction

  logic [NUM_BTN-1:0] btn_meta, btn_sync;
  logic [NUM_BTN-1:0] db_level, press;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];
  logic               press_any;
  logic [IDX_W-1:0]   press_idx;
  logic               fs_d, fs_rise;
  logic               wr_ok;
  preset_t            tbl [NUM_PRESETS];
  preset_t            sel, active;
  logic               sel_valid;
  state_t             state, state_nx;
  logic [IDX_W-1:0]   req_idx, req_nx;

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
    end
  end

  // Debounce: the level follows the input only after DB_CYCLES consecutive
  // differing samples; any sample that agrees with the level reloads the
  // counter. A 0->1 level change produces a one-cycle press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level <= '0;
      press    <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      press <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_sync[i] != db_level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_level[i] <= btn_sync[i];
            press[i]    <= btn_sync[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Simultaneous presses resolve to the lowest button index.
  always_comb begin
    press_any = |press;
    press_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--)
      if (press[i]) press_idx = IDX_W'(i);
  end

  // frame_sync may be a level, so only its rising edge starts a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fs_d <= 1'b0;
    else     fs_d <= frame_sync;
  end
  assign fs_rise = frame_sync & ~fs_d;

  assign wr_ok = cfg_we && (int'(cfg_addr) < NUM_PRESETS) && (cfg_field != 3'd7);

  // Preset table. Being non-blocking, a write in the APPLY cycle is not
  // seen by that commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRESETS; i++) tbl[i] <= reset_preset(i);
    end else if (wr_ok) begin
      case (cfg_field)
        3'd0:    tbl[cfg_addr].x_bgn <= cfg_wdata[IW-1:0];
        3'd1:    tbl[cfg_addr].x_end <= cfg_wdata[IW-1:0];
        3'd2:    tbl[cfg_addr].y_bgn <= cfg_wdata[IW-1:0];
        3'd3:    tbl[cfg_addr].in_x  <= cfg_wdata[IW-1:0];
        3'd4:    tbl[cfg_addr].in_y  <= cfg_wdata[IW-1:0];
        3'd5:    tbl[cfg_addr].out_x <= cfg_wdata;
        3'd6:    tbl[cfg_addr].out_y <= cfg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_idx <= '0;
    end else begin
      state   <= state_nx;
      req_idx <= req_nx;
    end
  end

  // Next-state logic. Rewriting the live entry while idle re-arms a commit
  // of that same entry so the scaler picks up the change at the next frame.
  always_comb begin
    state_nx = state;
    req_nx   = req_idx;
    case (state)
      IDLE: begin
        if (press_any) begin
          state_nx = PENDING;
          req_nx   = press_idx;
        end else if (wr_ok && cfg_addr == active_idx) begin
          state_nx = PENDING;
          req_nx   = active_idx;
        end
      end
      PENDING: begin
        if (press_any) req_nx = press_idx;
        if (fs_rise)   state_nx = APPLY;
      end
      APPLY:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sel       = tbl[req_idx];
  assign sel_valid = (sel.x_end > sel.x_bgn) && (sel.in_x != '0) && (sel.in_y != '0)
                     && (sel.out_x != '0) && (sel.out_y != '0);

  // Active registers and status pulses change together on the edge that
  // leaves APPLY, keeping the scaler inputs glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active      <= reset_preset(0);
      active_idx  <= '0;
      cfg_applied <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_applied <= 1'b0;
      cfg_err     <= 1'b0;
      if (state == APPLY) begin
        if (sel_valid) begin
          active      <= sel;
          active_idx  <= req_idx;
          cfg_applied <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

  assign xBgn        = active.x_bgn;
  assign xEnd        = active.x_end;
  assign yBgn        = active.y_bgn;
  assign inXRes      = active.in_x;
  assign inYRes      = active.in_y;
  assign outXRes     = active.out_x;
  assign outYRes     = active.out_y;
  assign cfg_pending = (state == PENDING);

endmodule

// File: tb/tb_scaler_cfg_ctrl.sv
module tb_scaler_cfg_ctrl;

  localparam int DB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  button;
  logic        frame_sync;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [2:0]  cfg_field;
  logic [11:0] cfg_wdata;
  logic [10:0] xBgn, xEnd, yBgn, inXRes, inYRes;
  logic [11:0] outXRes, outYRes;
  logic [1:0]  active_idx;
  logic        cfg_pending, cfg_applied, cfg_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: table and active preset as plain integer arrays,
  // field order xBgn, xEnd, yBgn, inX, inY, outX, outY.
  int tbl [4][7];
  int act [7];
  int act_idx;
  bit pend;
  int req;

  scaler_cfg_ctrl #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .button(button), .frame_sync(frame_sync),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
    .xBgn(xBgn), .xEnd(xEnd), .yBgn(yBgn), .inXRes(inXRes), .inYRes(inYRes),
    .outXRes(outXRes), .outYRes(outYRes), .active_idx(active_idx),
    .cfg_pending(cfg_pending), .cfg_applied(cfg_applied), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      tbl[i] = '{0, 1023, 0, 1024, 768, 1024, 768};
    end
    tbl[1][1] = 767;
    tbl[2][1] = 511;
    tbl[3][5] = 512;
    tbl[3][6] = 384;
    act     = tbl[0];
    act_idx = 0;
    pend    = 0;
    req     = 0;
  endtask

  task automatic checkActive(input string tag);
    checkOutput({tag, ".xBgn"}, int'(xBgn), act[0]);
    checkOutput({tag, ".xEnd"}, int'(xEnd), act[1]);
    checkOutput({tag, ".yBgn"}, int'(yBgn), act[2]);
    checkOutput({tag, ".inXRes"}, int'(inXRes), act[3]);
    checkOutput({tag, ".inYRes"}, int'(inYRes), act[4]);
    checkOutput({tag, ".outXRes"}, int'(outXRes), act[5]);
    checkOutput({tag, ".outYRes"}, int'(outYRes), act[6]);
    checkOutput({tag, ".active_idx"}, int'(active_idx), act_idx);
    checkOutput({tag, ".pending"}, int'(cfg_pending), int'(pend));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    checkActive("reset");
  endtask

  // Clean press long enough to debounce, followed by a clean release.
  task automatic doPress(input int b);
    @(negedge clk);
    button[b] = 1'b1;
    repeat (DB + 6) @(negedge clk);
    pend = 1;
    req  = b;
    checkOutput($sformatf("press%0d.pending", b), int'(cfg_pending), 1);
    button[b] = 1'b0;
    repeat (DB + 6) @(negedge clk);
  endtask

  // Glitch one sample short of the debounce window: no event expected.
  task automatic doBounce(input int b);
    @(negedge clk);
    button[b] = 1'b1;
    repeat (DB - 1) @(negedge clk);
    button[b] = 1'b0;
    repeat (8) @(negedge clk);
    checkActive($sformatf("bounce%0d", b));
  endtask

  task automatic doWrite(input int addr, input int field, input int data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 2'(addr);
    cfg_field = 3'(field);
    cfg_wdata = 12'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    if (field != 7) begin
      tbl[addr][field] = (field < 5) ? (data & 2047) : (data & 4095);
      if (!pend && addr == act_idx) begin
        pend = 1;
        req  = act_idx;
      end
    end
    checkActive("write");
  endtask

  // Frame edge: outputs must still be old one clock later and new two
  // clocks later; frame_sync is held as a level to exercise edge use.
  task automatic doFrame();
    bit ok, exp_app, exp_err;
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    checkOutput("frame.pending_cleared", int'(cfg_pending), 0);
    checkOutput("frame.latency_outX", int'(outXRes), act[5]);
    exp_app = 0;
    exp_err = 0;
    if (pend) begin
      ok = (tbl[req][1] > tbl[req][0]) && tbl[req][3] != 0 && tbl[req][4] != 0
           && tbl[req][5] != 0 && tbl[req][6] != 0;
      if (ok) begin
        act     = tbl[req];
        act_idx = req;
        exp_app = 1;
      end else begin
        exp_err = 1;
      end
      pend = 0;
    end
    @(negedge clk);
    checkActive("frame");
    checkOutput("frame.applied", int'(cfg_applied), int'(exp_app));
    checkOutput("frame.err", int'(cfg_err), int'(exp_err));
    frame_sync = 1'b0;
    @(negedge clk);
    checkOutput("frame.applied_once", int'(cfg_applied), 0);
    checkOutput("frame.err_once", int'(cfg_err), 0);
  endtask

  task automatic applyStimulus(input int op);
    int f, d;
    case (op)
      0, 1: doPress($urandom_range(0, 3));
      2, 3: begin
        f = $urandom_range(0, 7);
        d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 4095);
        doWrite($urandom_range(0, 3), f, d);
      end
      4, 5: doFrame();
      6:    doBounce($urandom_range(0, 3));
      default: doReset();
    endcase
  endtask

  initial begin
    rst        = 1'b1;
    button     = '0;
    frame_sync = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_field  = '0;
    cfg_wdata  = '0;
    modelReset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkActive("init");

    $display("[TB] directed sequences");
    doPress(2);
    doFrame();
    doBounce(1);
    doPress(1);
    doPress(3);
    doFrame();
    doReset();
    doWrite(3, 0, 1023);
    doPress(3);
    doFrame();
    doWrite(0, 5, 800);
    doFrame();
    doWrite(0, 5, 900);
    doReset();
    doWrite(2, 7, 5);
    doFrame();

    $display("[TB] randomized sequences");
    for (int n = 0; n < 60; n++) applyStimulus($urandom_range(0, 7));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
